hs_npu_mem_wr_burst: RTL and testbench
======================================

# hs_npu_mem_wr_burst

Write-side burst generator between the NPU result writer and the AXI4 memory master port (`mem_aw*`, `mem_w*`, `mem_b*`).
- Accepts one write command (word-aligned base address plus word count) and a valid/ready stream of 32-bit result words.
- Splits the transfer into INCR bursts that never exceed `MAX_BURST` beats and never cross a 4 KB boundary.
- Tracks outstanding write responses and signals completion and error back to the NPU controller.

## Interface
Parameters:
- `MAX_BURST`, 16: maximum beats per burst; power of two, 1..256.
- `MAX_OUTST`, 4: maximum bursts awaiting a B response.
- `AXI_ID`, 8'h00: constant `awid`.

Ports:
- `clk_npu` in 1: single clock; everything is sampled on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_addr` in 32: byte address; bits [1:0] are ignored and treated as 0.
- `cmd_words` in 16: number of 32-bit words; 0 is legal.
- `data_valid` in 1 / `data_ready` out 1 / `data` in 32: result word stream.
- `busy` out 1: a command is in progress.
- `done` out 1: one-cycle pulse when a command completes.
- `err` out 1: error flag for the last completed command; valid from the `done` pulse until the next command is accepted.
- `mem_awvalid` out 1, `mem_awready` in 1, `mem_awid` out 8, `mem_awaddr` out 32, `mem_awlen` out 8, `mem_awsize` out 3, `mem_awburst` out 2.
- `mem_wvalid` out 1, `mem_wready` in 1, `mem_wdata` out 32, `mem_wstrb` out 4, `mem_wlast` out 1.
- `mem_bvalid` in 1, `mem_bready` out 1, `mem_bid` in 8, `mem_bresp` in 2.

## Operation
- FSM states: IDLE, AW, W, DRAIN, DONE.
- **IDLE:** `cmd_ready`=1. When `cmd_valid` is high:
  - latch the address and word count; clear `err`;
  - go to DRAIN if `cmd_words`=0, otherwise go to AW.
- **AW:**
  - Burst length = min(remaining words, `MAX_BURST`, (4096 − addr[11:0]) / 4).
  - Drive `awaddr` = current address, `awlen` = length − 1, `awsize`=3'b010, `awburst`=2'b01, `awid`=`AXI_ID`.
  - `awvalid` is deasserted while the outstanding count equals `MAX_OUTST`.
  - On the AW handshake: outstanding +1, address += 4·length, load the beat counter, go to W.
- **W:**
  - `mem_wvalid`=`data_valid`, `data_ready`=`mem_wready`, `wdata`=`data`, `wstrb`=4'hF.
  - `wlast` is high when the beat counter equals 1.
  - On each W handshake: beat counter −1, remaining −1.
  - After the last beat: go to AW if remaining ≠ 0, otherwise go to DRAIN.
- **DRAIN:** wait until the outstanding count is 0, then go to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **B channel:**
  - `mem_bready`=1 in every state except during reset.
  - Each B handshake decrements the outstanding count.
  - `bresp[1]`=1 (SLVERR or DECERR) sets `err`, which stays set until the next command is accepted.
  - `bid` is ignored.
- **Simultaneous events:** an AW handshake and a B handshake in the same cycle leave the outstanding count unchanged.
- **Unexpected B:** a B handshake while the outstanding count is 0 sets `err` and does not decrement the count (no underflow).
- **Address wrap:** the address wraps modulo 2^32 with no special handling; the 4 KB rule already stops any burst from crossing 0xFFFF_FFFF.

## Timing
- **Reset values:**
  - FSM in IDLE, all counters 0.
  - `busy`, `done`, `err`, `mem_awvalid`, `mem_wvalid`, `mem_wlast`, `data_ready` = 0; `cmd_ready` = 1.
  - `mem_bready` = 0 while `rst` is high.
  - AW payload outputs = 0.
- **Latency:**
  - Command accepted in cycle N → `awvalid` first asserted in cycle N+1.
  - AW handshake in cycle M → `wvalid` may be asserted in cycle M+1.
  - Last B handshake in cycle K → `done` in cycle K+2 (one cycle in DRAIN, then DONE).
  - Zero-word command accepted in cycle N → `done` in cycle N+2.
- **`busy`:** high from the cycle after command acceptance through the DONE cycle.
- **AW hold:** `awvalid` and the AW payload stay stable until `awready`.
- **W path:** fully combinational between the data stream and the W channel; no data buffering.
- **Ordering:** W beats for a burst are issued only after that burst's AW handshake.
- **Reset mid-operation:** everything aborts immediately; in-flight AXI transactions are not tracked. The interconnect must be reset together with this block.

## Structure
- In `hs_npu_pkg`:
  - state enum `mem_wr_state_t`;
  - constants `AXI_BURST_INCR`=2'b01, `AXI_SIZE_4B`=3'b010, `AXI_4K_BYTES`=4096.
- One sub-module, `hs_npu_burst_len`: combinational function of (addr[11:2], remaining, `MAX_BURST`) giving the burst length, so it can be tested on its own.
- The outstanding counter is `$clog2(MAX_OUTST+1)` bits wide.

## Test plan
- **Single burst:** addr 0x1000, 4 words, no backpressure → one AW with awaddr=0x1000, awlen=3; 4 W beats with wlast on the 4th; one OKAY B; `done` pulse, `err`=0.
- **Multi-burst:** addr 0x0, 40 words → AWs at 0x000/0x040/0x080 with awlen 15/15/7; exactly 40 W beats; 3 wlast pulses.
- **4 KB crossing:** addr 0x0FF8, 8 words → AW 0x0FF8 awlen=1, then AW 0x1000 awlen=5.
- **Outstanding limit:** `MAX_OUTST`=4, 80 words, B responses withheld → `awvalid` stays low after the 4th AW; releasing one B lets the 5th AW issue; all data words arrive in order.
- **Error and zero-length:** second B returns 2'b10 → `err`=1 at `done`. A following command accepted in cycle N with 0 words clears `err` at acceptance, produces no bus traffic, and gives `done` in cycle N+2.
- **Random backpressure and reset:** random `awready`/`wready`/`data_valid` → data integrity holds and `wlast` counts are correct. Asserting `rst` mid-burst → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/hs_npu_pkg.sv
// Shared types and AXI constants for the NPU memory write path.
//   mem_wr_state_t : write-burst FSM states
//   AXI_*          : fixed AXI4 encodings and the 4 KB burst boundary
package hs_npu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AW    = 3'd1,
        ST_W     = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } mem_wr_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam int         AXI_4K_BYTES   = 4096;

endpackage

// File: rtl/hs_npu_burst_len.sv
// Burst length for the next AW: min(remaining, MAX_BURST, words left in 4 KB page).
//   addr_word : address bits [11:2] (word offset inside the 4 KB page)
//   remaining : words still to send
//   len       : beats in the next burst (0 only when remaining is 0)
module hs_npu_burst_len
    import hs_npu_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic [9:0]  addr_word,
    input  logic [15:0] remaining,
    output logic [8:0]  len
);

    localparam logic [10:0] WORDS_4K = 11'(AXI_4K_BYTES / 4);
    localparam logic [15:0] MB       = 16'(MAX_BURST);

    // Words up to the page end: 1..1024, so an aligned address gives a full page.
    logic [10:0] room;
    logic [15:0] l;

    assign room = WORDS_4K - {1'b0, addr_word};

    always_comb begin
        l = remaining;
        if (l > MB)
            l = MB;
        if (l > {5'b0, room})
            l = {5'b0, room};
        len = 9'(l);
    end

endmodule

// File: rtl/hs_npu_mem_wr_burst.sv
// Write-side burst generator: NPU result stream -> AXI4 write master.
// Splits one command (base address + word count) into INCR bursts bounded by
// MAX_BURST beats and the 4 KB page, limits bursts awaiting B to MAX_OUTST,
// and reports done/err back to the controller.
//   cmd_*    : command handshake (addr byte-aligned to words, words may be 0)
//   data_*   : 32-bit result word stream, passed straight through to W
//   busy     : command in progress; done: 1-cycle completion pulse
//   err      : SLVERR/DECERR or unexpected B seen during the last command
//   mem_aw*/mem_w*/mem_b* : AXI4 write channels
module hs_npu_mem_wr_burst
    import hs_npu_pkg::*;
#(
    parameter int         MAX_BURST = 16,
    parameter int         MAX_OUTST = 4,
    parameter logic [7:0] AXI_ID    = 8'h00
) (
    input  logic        clk_npu,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [15:0] cmd_words,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [31:0] data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_awvalid,
    input  logic        mem_awready,
    output logic [7:0]  mem_awid,
    output logic [31:0] mem_awaddr,
    output logic [7:0]  mem_awlen,
    output logic [2:0]  mem_awsize,
    output logic [1:0]  mem_awburst,
    output logic        mem_wvalid,
    input  logic        mem_wready,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        mem_wlast,
    input  logic        mem_bvalid,
    output logic        mem_bready,
    input  logic [7:0]  mem_bid,
    input  logic [1:0]  mem_bresp
);

    localparam int            OW         = $clog2(MAX_OUTST + 1);
    localparam logic [OW-1:0] OUTST_FULL = OW'(MAX_OUTST);

    mem_wr_state_t state;
    logic [31:0]   addr_q;
    logic [15:0]   remaining;
    logic [8:0]    beats;
    logic [OW-1:0] outst;
    logic          err_q;
    logic [8:0]    burst_len;
    logic          in_aw, in_w;
    logic          aw_hs, w_hs, b_hs, b_dec;
    logic          unused_bits;

    // Word alignment drops addr[1:0]; B ID and the OKAY/EXOKAY bit carry no info here.
    assign unused_bits = ^{cmd_addr[1:0], mem_bid, mem_bresp[0]};

    hs_npu_burst_len #(.MAX_BURST(MAX_BURST)) u_burst_len (
        .addr_word (addr_q[11:2]),
        .remaining (remaining),
        .len       (burst_len)
    );

    assign in_aw = (state == ST_AW);
    assign in_w  = (state == ST_W);

    // AW payload comes from registers that are frozen while in AW, so it holds
    // until awready; it reads as zero outside AW.
    assign mem_awvalid = in_aw && (outst != OUTST_FULL);
    assign mem_awid    = in_aw ? AXI_ID : 8'h00;
    assign mem_awaddr  = in_aw ? addr_q : 32'h0;
    assign mem_awlen   = in_aw ? 8'(burst_len - 9'd1) : 8'h00;
    assign mem_awsize  = in_aw ? AXI_SIZE_4B : 3'b000;
    assign mem_awburst = in_aw ? AXI_BURST_INCR : 2'b00;

    // W is a pure pass-through of the data stream, gated to the W state.
    assign mem_wvalid = in_w && data_valid;
    assign data_ready = in_w && mem_wready;
    assign mem_wdata  = data;
    assign mem_wstrb  = in_w ? 4'hF : 4'h0;
    assign mem_wlast  = in_w && (beats == 9'd1);

    assign mem_bready = !rst;
    assign cmd_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign err        = err_q;

    assign aw_hs = mem_awvalid && mem_awready;
    assign w_hs  = mem_wvalid && mem_wready;
    assign b_hs  = mem_bvalid && mem_bready;
    // A B with nothing outstanding is flagged but never underflows the count.
    assign b_dec = b_hs && (outst != '0);

    always_ff @(posedge clk_npu) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_q    <= 32'h0;
            remaining <= 16'h0;
            beats     <= 9'h0;
            outst     <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    addr_q    <= {cmd_addr[31:2], 2'b00};
                    remaining <= cmd_words;
                    err_q     <= 1'b0;
                    state     <= (cmd_words == 16'h0) ? ST_DRAIN : ST_AW;
                end
                ST_AW: if (aw_hs) begin
                    addr_q <= addr_q + {21'h0, burst_len, 2'b00};
                    beats  <= burst_len;
                    state  <= ST_W;
                end
                ST_W: if (w_hs) begin
                    beats     <= beats - 9'd1;
                    remaining <= remaining - 16'd1;
                    if (beats == 9'd1)
                        state <= (remaining != 16'd1) ? ST_AW : ST_DRAIN;
                end
                ST_DRAIN: if (outst == '0) state <= ST_DONE;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase

            // Placed after the command clear so a same-cycle bad B still wins.
            if (b_hs && (mem_bresp[1] || outst == '0))
                err_q <= 1'b1;

            if (aw_hs && !b_dec)
                outst <= outst + OW'(1);
            else if (!aw_hs && b_dec)
                outst <= outst - OW'(1);
        end
    end

endmodule

// File: tb/tb_hs_npu_mem_wr_burst.sv
module tb_hs_npu_mem_wr_burst;

    logic        clk_npu = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_words;
    logic        data_valid, data_ready;
    logic [31:0] data;
    logic        busy, done, err;
    logic        mem_awvalid, mem_awready;
    logic [7:0]  mem_awid, mem_awlen;
    logic [31:0] mem_awaddr;
    logic [2:0]  mem_awsize;
    logic [1:0]  mem_awburst;
    logic        mem_wvalid, mem_wready, mem_wlast;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_bvalid, mem_bready;
    logic [7:0]  mem_bid;
    logic [1:0]  mem_bresp;

    always #5 clk_npu = ~clk_npu;

    hs_npu_mem_wr_burst #(.MAX_BURST(16), .MAX_OUTST(4), .AXI_ID(8'h00)) dut (
        .clk_npu(clk_npu), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_words(cmd_words),
        .data_valid(data_valid), .data_ready(data_ready), .data(data),
        .busy(busy), .done(done), .err(err),
        .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_awid(mem_awid),
        .mem_awaddr(mem_awaddr), .mem_awlen(mem_awlen), .mem_awsize(mem_awsize), .mem_awburst(mem_awburst),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_wlast(mem_wlast),
        .mem_bvalid(mem_bvalid), .mem_bready(mem_bready), .mem_bid(mem_bid), .mem_bresp(mem_bresp)
    );

    int errors = 0, checks = 0, cyc = 0;

    // bus-side logs and slave/source state
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [31:0] w_data_q[$];
    int  wlast_cnt, wb_idx, wb_beat, viol;
    int  pending_b = 0, b_count = 0, b_err_idx = -1;
    bit  b_hold = 0, force_b = 0, aw_rnd = 0, w_rnd = 0, dv_rnd = 0, b_rnd = 0;
    int  src_n = 0, src_i = 0;
    logic [31:0] src_base = 32'h0;
    int  acc_cyc, first_aw_cyc, done_cyc, last_b_cyc, done_cnt;
    logic err_at_done;
    bit  aw_seen, aw_pend;
    logic [31:0] aw_pend_addr;
    logic [7:0]  aw_pend_len;

    // slave and data source drive on the falling edge
    always @(negedge clk_npu) begin
        mem_awready = aw_rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        mem_wready  = w_rnd  ? ($urandom_range(0, 1) == 1) : 1'b1;
        data_valid  = (src_i < src_n) && (dv_rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
        data        = src_base + 32'(src_i);
        mem_bvalid  = force_b || (pending_b > 0 && !b_hold && (b_rnd ? ($urandom_range(0, 2) == 0) : 1'b1));
        mem_bresp   = (b_count == b_err_idx) ? 2'b10 : 2'b00;
        mem_bid     = 8'h00;
    end

    // handshake monitor: values seen here are the pre-edge values
    always @(posedge clk_npu) begin
        if (rst) begin
            pending_b = 0;
            aw_pend   = 0;
        end else begin
            if (cmd_valid && cmd_ready) begin acc_cyc = cyc; aw_seen = 0; end
            if (mem_awvalid && !aw_seen) begin first_aw_cyc = cyc; aw_seen = 1; end
            if (aw_pend && (!mem_awvalid || mem_awaddr !== aw_pend_addr || mem_awlen !== aw_pend_len)) viol++;
            aw_pend = mem_awvalid && !mem_awready;
            aw_pend_addr = mem_awaddr;
            aw_pend_len  = mem_awlen;
            if (mem_wvalid && mem_wready) begin
                w_data_q.push_back(mem_wdata);
                if (mem_wstrb !== 4'hF) viol++;
                if (wb_idx < aw_len_q.size()) begin
                    if (mem_wlast !== (wb_beat == int'(aw_len_q[wb_idx]))) viol++;
                    if (wb_beat == int'(aw_len_q[wb_idx])) begin wb_idx++; wb_beat = 0; end
                    else wb_beat++;
                end else viol++;
                if (mem_wlast) begin wlast_cnt++; pending_b++; end
            end
            if (mem_awvalid && mem_awready) begin
                aw_addr_q.push_back(mem_awaddr);
                aw_len_q.push_back(mem_awlen);
                if (mem_awsize !== 3'b010 || mem_awburst !== 2'b01 || mem_awid !== 8'h00) viol++;
            end
            if (data_valid && data_ready) src_i++;
            if (mem_bvalid && mem_bready) begin
                if (pending_b > 0) pending_b--;
                b_count++;
                last_b_cyc = cyc;
            end
            if (done) begin done_cyc = cyc; done_cnt++; err_at_done = err; end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk_npu);
        #1;
    endtask

    task automatic clear_logs();
        aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete();
        wlast_cnt = 0; wb_idx = 0; wb_beat = 0; viol = 0;
        b_count = 0; done_cnt = 0; err_at_done = 1'bx;
    endtask

    task automatic start_cmd(input logic [31:0] a, input int words);
        src_base = 32'hD000_0000 + (a << 4);
        src_n = words;
        src_i = 0;
        for (int i = 0; i < 50 && !cmd_ready; i++) tick();
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_words = 16'(words);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string name);
        int n = done_cnt;
        for (int i = 0; i < maxc && done_cnt == n; i++) tick();
        checks++;
        if (done_cnt == n) begin
            errors++;
            $display("FAIL %s_done: no done within %0d cycles", name, maxc);
        end
    endtask

    function automatic int data_mism(input int n);
        int m = 0;
        if (w_data_q.size() != n) m++;
        for (int i = 0; i < w_data_q.size() && i < n; i++)
            if (w_data_q[i] !== src_base + 32'(i)) m++;
        return m;
    endfunction

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_words = '0;
        tick(); tick();
        checks++;
        if (mem_bready !== 1'b0) begin errors++; $display("FAIL reset_bready: got %b exp 0", mem_bready); end
        checks++;
        if ({cmd_ready, busy, done, err, mem_awvalid, mem_wvalid, mem_wlast, data_ready} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b exp 10000000",
                     {cmd_ready, busy, done, err, mem_awvalid, mem_wvalid, mem_wlast, data_ready});
        end
        checks++;
        if ({mem_awaddr, mem_awlen, mem_awsize, mem_awburst, mem_awid} !== 53'h0) begin
            errors++; $display("FAIL reset_aw_payload: got addr %h len %h", mem_awaddr, mem_awlen);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (mem_bready !== 1'b1) begin errors++; $display("FAIL post_reset_bready: got %b exp 1", mem_bready); end
    endtask

    task automatic test_single();
        clear_logs();
        start_cmd(32'h0000_1000, 4);
        checks++;
        if ({busy, err} !== 2'b10) begin errors++; $display("FAIL single_busy: got busy/err %b exp 10", {busy, err}); end
        wait_done(100, "single");
        checks++;
        if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h1000 || aw_len_q[0] !== 8'd3) begin
            errors++; $display("FAIL single_aw: got %0d AWs first %h/%0d exp 1 AW 1000/3",
                               aw_addr_q.size(), aw_addr_q[0], aw_len_q[0]);
        end
        checks++;
        if (data_mism(4) != 0 || wlast_cnt != 1) begin
            errors++; $display("FAIL single_w: got %0d beats %0d wlast exp 4/1", w_data_q.size(), wlast_cnt);
        end
        checks++;
        if (err_at_done !== 1'b0) begin errors++; $display("FAIL single_err: got %b exp 0", err_at_done); end
        checks++;
        if (first_aw_cyc != acc_cyc + 1) begin
            errors++; $display("FAIL single_aw_latency: got %0d exp %0d", first_aw_cyc, acc_cyc + 1);
        end
        checks++;
        if (done_cyc != last_b_cyc + 2) begin
            errors++; $display("FAIL single_done_latency: got %0d exp %0d", done_cyc, last_b_cyc + 2);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt != 1) begin
            errors++; $display("FAIL single_done_pulse: got done %b busy %b pulses %0d exp 0 0 1", done, busy, done_cnt);
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL single_protocol: got %0d violations exp 0", viol); end
    endtask

    task automatic test_multi();
        logic [31:0] ea[3] = '{32'h000, 32'h040, 32'h080};
        logic [7:0]  el[3] = '{8'd15, 8'd15, 8'd7};
        int m = 0;
        clear_logs();
        start_cmd(32'h0, 40);
        wait_done(400, "multi");
        if (aw_addr_q.size() != 3) m++;
        for (int i = 0; i < 3 && i < aw_addr_q.size(); i++)
            if (aw_addr_q[i] !== ea[i] || aw_len_q[i] !== el[i]) m++;
        checks++;
        if (m != 0) begin errors++; $display("FAIL multi_aw: got %0d AWs with %0d mismatches exp 3 exact", aw_addr_q.size(), m); end
        checks++;
        if (data_mism(40) != 0 || wlast_cnt != 3) begin
            errors++; $display("FAIL multi_w: got %0d beats %0d wlast exp 40/3", w_data_q.size(), wlast_cnt);
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL multi_protocol: got %0d violations exp 0", viol); end
    endtask

    task automatic test_4k_cross();
        clear_logs();
        start_cmd(32'h0000_0FF8, 8);
        wait_done(200, "cross4k");
        checks++;
        if (aw_addr_q.size() != 2 || aw_addr_q[0] !== 32'h0FF8 || aw_len_q[0] !== 8'd1 ||
            aw_addr_q[1] !== 32'h1000 || aw_len_q[1] !== 8'd5) begin
            errors++; $display("FAIL cross4k_aw: got %0d AWs %h/%0d %h/%0d exp 0FF8/1 1000/5",
                               aw_addr_q.size(), aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]);
        end
        checks++;
        if (data_mism(8) != 0 || wlast_cnt != 2 || viol != 0) begin
            errors++; $display("FAIL cross4k_w: got %0d beats %0d wlast %0d viol exp 8/2/0", w_data_q.size(), wlast_cnt, viol);
        end
    endtask

    task automatic test_outstanding();
        clear_logs();
        b_hold = 1;
        start_cmd(32'h0000_2000, 80);
        for (int i = 0; i < 400 && w_data_q.size() < 64; i++) tick();
        repeat (5) tick();
        checks++;
        if (aw_addr_q.size() != 4 || mem_awvalid !== 1'b0 || busy !== 1'b1 || w_data_q.size() != 64) begin
            errors++; $display("FAIL outst_stall: got %0d AWs awvalid %b beats %0d exp 4 0 64",
                               aw_addr_q.size(), mem_awvalid, w_data_q.size());
        end
        b_hold = 0;
        for (int i = 0; i < 20 && b_count == 0; i++) tick();
        b_hold = 1;
        for (int i = 0; i < 20 && aw_addr_q.size() < 5; i++) tick();
        checks++;
        if (aw_addr_q.size() != 5 || aw_addr_q[4] !== 32'h2100 || aw_len_q[4] !== 8'd15 || b_count != 1) begin
            errors++; $display("FAIL outst_release: got %0d AWs last %h Bs %0d exp 5 2100 1",
                               aw_addr_q.size(), aw_addr_q[aw_addr_q.size() - 1], b_count);
        end
        b_hold = 0;
        wait_done(300, "outst");
        checks++;
        if (data_mism(80) != 0 || wlast_cnt != 5 || viol != 0 || err_at_done !== 1'b0) begin
            errors++; $display("FAIL outst_data: got %0d beats %0d wlast %0d viol err %b exp 80/5/0/0",
                               w_data_q.size(), wlast_cnt, viol, err_at_done);
        end
    endtask

    task automatic test_err_zero();
        clear_logs();
        b_err_idx = 1;
        start_cmd(32'h0000_3000, 32);
        wait_done(300, "err");
        checks++;
        if (err_at_done !== 1'b1) begin errors++; $display("FAIL err_at_done: got %b exp 1", err_at_done); end
        b_err_idx = -1;
        repeat (3) tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_hold_idle: got %b exp 1", err); end
        clear_logs();
        start_cmd(32'h0000_4000, 0);
        checks++;
        if ({busy, err} !== 2'b10) begin errors++; $display("FAIL zero_accept: got busy/err %b exp 10", {busy, err}); end
        wait_done(20, "zero");
        checks++;
        if (done_cyc != acc_cyc + 2) begin errors++; $display("FAIL zero_latency: got %0d exp %0d", done_cyc, acc_cyc + 2); end
        checks++;
        if (aw_addr_q.size() != 0 || w_data_q.size() != 0 || err_at_done !== 1'b0) begin
            errors++; $display("FAIL zero_traffic: got %0d AWs %0d beats err %b exp 0 0 0",
                               aw_addr_q.size(), w_data_q.size(), err_at_done);
        end
    endtask

    task automatic test_unexpected_b();
        clear_logs();
        tick();
        force_b = 1;
        tick();
        force_b = 0;
        tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL unexp_b_err: got %b exp 1", err); end
        clear_logs();
        start_cmd(32'h0000_5000, 1);
        wait_done(60, "unexp_b");
        checks++;
        if (aw_addr_q.size() != 1 || aw_len_q[0] !== 8'd0 || err_at_done !== 1'b0 || data_mism(1) != 0) begin
            errors++; $display("FAIL unexp_b_next: got %0d AWs len %0d err %b exp 1 0 0",
                               aw_addr_q.size(), aw_len_q[0], err_at_done);
        end
    endtask

    task automatic test_random();
        clear_logs();
        aw_rnd = 1; w_rnd = 1; dv_rnd = 1; b_rnd = 1;
        start_cmd(32'h0000_0FC0, 100);
        wait_done(4000, "random");
        aw_rnd = 0; w_rnd = 0; dv_rnd = 0; b_rnd = 0;
        checks++;
        if (aw_addr_q.size() != 7 || aw_addr_q[0] !== 32'h0FC0 || aw_len_q[0] !== 8'd15 ||
            aw_addr_q[1] !== 32'h1000 || aw_addr_q[6] !== 32'h1140 || aw_len_q[6] !== 8'd3) begin
            errors++; $display("FAIL random_aw: got %0d AWs first %h last %h exp 7 0FC0 1140",
                               aw_addr_q.size(), aw_addr_q[0], aw_addr_q[aw_addr_q.size() - 1]);
        end
        checks++;
        if (data_mism(100) != 0 || wlast_cnt != 7 || viol != 0) begin
            errors++; $display("FAIL random_w: got %0d beats %0d wlast %0d viol exp 100/7/0",
                               w_data_q.size(), wlast_cnt, viol);
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        start_cmd(32'h0000_6000, 40);
        for (int i = 0; i < 100 && w_data_q.size() < 5; i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({cmd_ready, busy, done, err, mem_awvalid, mem_wvalid, mem_wlast, data_ready, mem_bready} !== 9'b1_0000_0000 ||
            {mem_awaddr, mem_awlen, mem_awsize, mem_awburst, mem_awid} !== 53'h0) begin
            errors++; $display("FAIL mid_reset: got ctrl %b awaddr %h exp 100000000 0",
                               {cmd_ready, busy, done, err, mem_awvalid, mem_wvalid, mem_wlast, data_ready, mem_bready}, mem_awaddr);
        end
        rst = 1'b0;
        src_n = 0;
        tick();
        clear_logs();
        start_cmd(32'h0000_7000, 2);
        wait_done(60, "recover");
        checks++;
        if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h7000 || aw_len_q[0] !== 8'd1 ||
            data_mism(2) != 0 || err_at_done !== 1'b0) begin
            errors++; $display("FAIL recover: got %0d AWs %h beats %0d err %b exp 1 7000 2 0",
                               aw_addr_q.size(), aw_addr_q[0], w_data_q.size(), err_at_done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_4k_cross();
        test_outstanding();
        test_err_zero();
        test_unexpected_b();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
